// File: rtl/comparator_100hz.sv
// comparator_100hz
//   Converts the count of an external free-running divider counter into a
//   registered 100 Hz square wave. With a 50 MHz clock and a 0..PERIOD-1
//   counter, the output is high for HIGH_LEN counts and low for the rest.
//   The block keeps no counter of its own: the only state is the output flop.
//   An out-of-range count (Cin >= PERIOD) forces the output low.
module comparator_100hz #(
  parameter int CNT_W    = 19,
  parameter int HIGH_LEN = 250000,
  parameter int PERIOD   = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] Cin,
  output logic             clk100_hz
);

  // Parameter sanity: a bad combination stops elaboration.
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_width
    $fatal(1, "comparator_100hz: CNT_W must be in 1..31");
  end
  if (HIGH_LEN <= 0 || HIGH_LEN > PERIOD) begin : g_bad_high_len
    $fatal(1, "comparator_100hz: HIGH_LEN must satisfy 0 < HIGH_LEN <= PERIOD");
  end
  if (longint'(PERIOD) > (longint'(1) << CNT_W)) begin : g_bad_period
    $fatal(1, "comparator_100hz: PERIOD must satisfy PERIOD <= 2**CNT_W");
  end

  // Limits are one bit wider than Cin so PERIOD == 2**CNT_W is representable.
  localparam logic [CNT_W:0] HIGH_LIM   = (CNT_W+1)'(HIGH_LEN);
  localparam logic [CNT_W:0] PERIOD_LIM = (CNT_W+1)'(PERIOD);

  logic [CNT_W:0] cin_ext;
  logic           below_high;
  logic           in_range;
  logic           clk100_d;
  logic           clk100_q;

  assign cin_ext = {1'b0, Cin};

  // Unsigned magnitude compares; the high window is 0..HIGH_LEN-1 and any
  // count at or beyond PERIOD is treated as invalid and held low.
  always_comb begin
    below_high = 1'b0;
    in_range   = 1'b0;
    clk100_d   = 1'b0;
    below_high = (cin_ext < HIGH_LIM);
    in_range   = (cin_ext < PERIOD_LIM);
    clk100_d   = below_high & in_range;
  end

  // Output register: asynchronous clear, one clock of latency from Cin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk100_q <= 1'b0;
    end else begin
      clk100_q <= clk100_d;
    end
  end

  assign clk100_hz = clk100_q;

endmodule

// File: tb/tb_comparator_100hz.sv
// tb_comparator_100hz
//   Drives Cin on the falling edge and pushes the expected output into a
//   queue; a monitor pops one entry shortly after each rising edge and
//   compares. A second monitor checks the asynchronous clear on rst_n fall.
module tb_comparator_100hz;

  localparam int CNT_W  = 19;
  localparam int STRIDE = 16;
  localparam int NSWEEP = 524288 / STRIDE;

  // ---------------- clock / reset ----------------
  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] Cin;
  logic             clk100_hz;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  comparator_100hz #(
    .CNT_W    (CNT_W),
    .HIGH_LEN (250000),
    .PERIOD   (500000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Cin       (Cin),
    .clk100_hz (clk100_hz)
  );

  // ---------------- scoreboard state ----------------
  logic [0:0] exp_q[$];
  bit         tag_q[$];
  string      name_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int  sweep_hi    = 0;
  int  sweep_rises = 0;
  int  sweep_falls = 0;
  bit  sweep_prev  = 1'b0;

  // Golden model of the intended behaviour at default parameters.
  function automatic logic golden(input int unsigned c);
    return (c < 250000) ? 1'b1 : 1'b0;
  endfunction

  task automatic check_int(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_rst(input int unsigned c, input logic rst, input logic e,
                           input string nm);
    @(negedge clk);
    rst_n = rst;
    Cin   = CNT_W'(c);
    exp_q.push_back(e);
    tag_q.push_back(1'b0);
    name_q.push_back(nm);
  endtask

  task automatic drive(input int unsigned c, input logic e, input string nm);
    drive_rst(c, 1'b1, e, nm);
  endtask

  task automatic drive_sweep(input int unsigned c);
    @(negedge clk);
    Cin = CNT_W'(c);
    exp_q.push_back(golden(c));
    tag_q.push_back(1'b1);
    name_q.push_back("sweep");
  endtask

  // ---------------- monitors ----------------
  initial begin : monitor_sync
    logic [0:0] e;
    bit         t;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        t  = tag_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (clk100_hz !== e[0]) begin
          n_fail++;
          $display("FAIL %s: Cin=%0d clk100_hz=%b expected %b", nm, Cin, clk100_hz, e[0]);
        end
        if (t) begin
          if (clk100_hz === 1'b1) sweep_hi++;
          if (!sweep_prev && clk100_hz === 1'b1) sweep_rises++;
          if (sweep_prev && clk100_hz !== 1'b1) sweep_falls++;
          sweep_prev = (clk100_hz === 1'b1);
        end
      end
    end
  end

  initial begin : monitor_async_reset
    forever begin
      @(negedge rst_n);
      #1;
      n_checks++;
      if (clk100_hz !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset: clk100_hz=%b expected 0 before next clk", clk100_hz);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    rst_n = 1'b0;
    Cin   = '0;

    // Reset holds the output low whatever the count is.
    drive_rst(0,      1'b0, 1'b0, "reset_cin0");
    drive_rst(100,    1'b0, 1'b0, "reset_cin100");
    drive_rst(524287, 1'b0, 1'b0, "reset_cin_max");
    // Release with Cin=0: high after one edge.
    drive_rst(0,      1'b1, 1'b1, "release_cin0");

    // High/low boundary.
    drive(249999, 1'b1, "high_len_m1");
    drive(250000, 1'b0, "high_len");
    drive(249999, 1'b1, "high_len_m1_again");

    // Period boundary and out-of-range counts.
    drive(499999, 1'b0, "period_m1");
    drive(500000, 1'b0, "period");
    drive(0,      1'b1, "back_high");
    drive(524287, 1'b0, "all_ones");

    // Counter wrap edge.
    drive(499998, 1'b0, "wrap_499998");
    drive(499999, 1'b0, "wrap_499999");
    drive(0,      1'b1, "wrap_0");
    drive(1,      1'b1, "wrap_1");

    // Asynchronous reset while the output is high.
    drive(100, 1'b1, "pre_reset_high");
    drive(100, 1'b1, "pre_reset_high2");
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    drive_rst(100, 1'b0, 1'b0, "reset_hold1");
    drive_rst(100, 1'b0, 1'b0, "reset_hold2");
    drive_rst(100, 1'b0, 1'b0, "reset_hold3");
    drive_rst(100, 1'b1, 1'b1, "reset_release");

    // Dense windows around every boundary.
    for (int c = 249990; c <= 250010; c++) drive(c, golden(c), "win_high_len");
    for (int c = 499990; c <= 500010; c++) drive(c, golden(c), "win_period");
    for (int c = 524270; c <= 524287; c++) drive(c, golden(c), "win_top");

    // Strided sweep of the full input range.
    for (int i = 0; i < NSWEEP; i++) drive_sweep(i * STRIDE);

    // Let the monitor drain the queue.
    repeat (3) @(negedge clk);
    check_int("queue_drained", exp_q.size(), 0);
    // 0,16,...,249984 are the high samples: 250000/16 = 15625.
    check_int("sweep_high_count", sweep_hi, 15625);
    check_int("sweep_rises",      sweep_rises, 1);
    check_int("sweep_falls",      sweep_falls, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
